// File: rtl/mem_access_pkg.sv
// Shared definitions for the data-memory access path.
// Contents:
//   ACC_WORD/ACC_HALF/ACC_BYTE    mem_access_size encodings, shared with data_memory
//   FUNCT3_LB..FUNCT3_LHU         RV32I load/store funct3 codes
//   lsu_state_t                   load/store unit sequencer states
//   funct3_legal()                is a funct3 usable for a load or a store
//   acc_size()                    natural access size for a funct3
package mem_access_pkg;

  localparam logic [1:0] ACC_WORD = 2'b00;
  localparam logic [1:0] ACC_HALF = 2'b01;
  localparam logic [1:0] ACC_BYTE = 2'b10;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } lsu_state_t;

  // Stores only have signed-less b/h/w encodings; the unsigned variants are load-only.
  function automatic logic funct3_legal(input logic store, input logic [2:0] funct3);
    case (funct3)
      FUNCT3_LB, FUNCT3_LH, FUNCT3_LW: return 1'b1;
      FUNCT3_LBU, FUNCT3_LHU:          return ~store;
      default:                         return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] acc_size(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return ACC_BYTE;
      2'b01:   return ACC_HALF;
      default: return ACC_WORD;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Bus bundles around the load/store unit.
//   load_store_unit_if : pipeline request/response handshake
//     master = pipeline (drives req_*), slave = load/store unit (drives req_ready, resp_*)
//   mem_bus_if         : data-memory access port
//     master = load/store unit (drives mem_* controls), slave = memory (drives mem_rdata)
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata
  );
endinterface

interface mem_bus_if;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic        mem_load_s;
  logic [1:0]  mem_access_size;
  logic        mem_read_write;
  logic [31:0] mem_rdata;

  modport master (
    output mem_address, mem_wdata, mem_load_s, mem_access_size, mem_read_write,
    input  mem_rdata
  );

  modport slave (
    input  mem_address, mem_wdata, mem_load_s, mem_access_size, mem_read_write,
    output mem_rdata
  );
endinterface

// File: rtl/load_extend.sv
// Sign/zero extension of an assembled little-endian load value.
// Ports:
//   bytes_in  in  32  assembled bytes, byte 0 in [7:0]
//   funct3    in  3   RV32I load funct3 (b/h/w/bu/hu)
//   result    out 32  extended load result (other funct3 values pass through)
module load_extend
  import mem_access_pkg::*;
(
  input  logic [31:0] bytes_in,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  always_comb begin
    result = bytes_in;
    case (funct3)
      FUNCT3_LB:  result = {{24{bytes_in[7]}}, bytes_in[7:0]};
      FUNCT3_LH:  result = {{16{bytes_in[15]}}, bytes_in[15:0]};
      FUNCT3_LBU: result = {24'h0, bytes_in[7:0]};
      FUNCT3_LHU: result = {16'h0, bytes_in[15:0]};
      default:    result = bytes_in;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator for a byte-addressed data memory.
// Aligned requests are issued straight from the request in the accept cycle and
// complete one cycle later. Misaligned half/word requests are split into sequential
// byte accesses (byte 0 from the request, the rest from latched copies); loads are
// reassembled and extended locally. Illegal funct3, or misalignment when splitting
// is disabled, completes with resp_err and no memory access.
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   req_if         pipeline request/response (slave side)
//   mem_if         data-memory port (master side); mem_rdata is combinational
// Parameters:
//   BASE_ADDR         address driven while no access is in progress
//   ALLOW_MISALIGNED  1: split misaligned accesses, 0: report them as errors
module load_store_unit
  import mem_access_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR        = 32'h0100_0000,
  parameter bit          ALLOW_MISALIGNED = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  load_store_unit_if.slave req_if,
  mem_bus_if.master        mem_if
);

  lsu_state_t  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        store_q, store_d;
  logic [31:0] asm_q, asm_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;

  logic        req_aligned;
  logic        req_bad;
  logic [1:0]  last_cnt;
  logic [7:0]  split_wbyte;
  logic [31:0] asm_cur;
  logic [31:0] ext_result;

  // Assembly buffer with the byte arriving this cycle merged into lane cnt_q.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign asm_cur[8*gi +: 8] = (cnt_q == 2'(gi)) ? mem_if.mem_rdata[7:0] : asm_q[8*gi +: 8];
  end

  load_extend u_load_extend (
    .bytes_in (asm_cur),
    .funct3   (funct3_q),
    .result   (ext_result)
  );

  assign split_wbyte = wdata_q[{cnt_q, 3'b000} +: 8];
  // Halfwords split into 2 bytes, words into 4.
  assign last_cnt    = (funct3_q[1:0] == 2'b01) ? 2'd1 : 2'd3;

  always_comb begin
    case (req_if.req_funct3[1:0])
      2'b01:   req_aligned = ~req_if.req_addr[0];
      2'b10:   req_aligned = (req_if.req_addr[1:0] == 2'b00);
      default: req_aligned = 1'b1;
    endcase
    req_bad = ~funct3_legal(req_if.req_store, req_if.req_funct3) |
              (~req_aligned & ~ALLOW_MISALIGNED);
  end

  // Reset gates the memory drive so an in-flight split cannot write on the reset edge.
  assign req_if.req_ready = (state_q == IDLE) & ~reset;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    funct3_d     = funct3_q;
    store_d      = store_q;
    asm_d        = asm_q;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;

    mem_if.mem_address     = BASE_ADDR;
    mem_if.mem_wdata       = 32'h0;
    mem_if.mem_load_s      = 1'b0;
    mem_if.mem_access_size = ACC_WORD;
    mem_if.mem_read_write  = 1'b1;

    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (req_if.req_valid) begin
            if (req_bad) begin
              resp_valid_d = 1'b1;
              resp_err_d   = 1'b1;
              resp_rdata_d = 32'h0;
            end else if (req_aligned) begin
              // The memory extends aligned loads itself; its result is taken as is.
              mem_if.mem_address     = req_if.req_addr;
              mem_if.mem_wdata       = req_if.req_wdata;
              mem_if.mem_load_s      = ~req_if.req_funct3[2] & (req_if.req_funct3[1:0] != 2'b10);
              mem_if.mem_access_size = acc_size(req_if.req_funct3);
              mem_if.mem_read_write  = ~req_if.req_store;
              resp_valid_d = 1'b1;
              resp_err_d   = 1'b0;
              resp_rdata_d = req_if.req_store ? 32'h0 : mem_if.mem_rdata;
            end else begin
              // Byte 0 goes out now; the request is latched for the remaining bytes.
              mem_if.mem_address     = req_if.req_addr;
              mem_if.mem_wdata       = {24'h0, req_if.req_wdata[7:0]};
              mem_if.mem_access_size = ACC_BYTE;
              mem_if.mem_read_write  = ~req_if.req_store;
              addr_d   = req_if.req_addr;
              wdata_d  = req_if.req_wdata;
              funct3_d = req_if.req_funct3;
              store_d  = req_if.req_store;
              asm_d    = {24'h0, mem_if.mem_rdata[7:0]};
              cnt_d    = 2'd1;
              state_d  = SPLIT;
            end
          end
        end

        SPLIT: begin
          mem_if.mem_address     = addr_q + {30'h0, cnt_q};
          mem_if.mem_wdata       = {24'h0, split_wbyte};
          mem_if.mem_access_size = ACC_BYTE;
          mem_if.mem_read_write  = ~store_q;
          asm_d = asm_cur;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == last_cnt) begin
            state_d      = IDLE;
            cnt_d        = 2'd0;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            resp_rdata_d = store_q ? 32'h0 : ext_result;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      funct3_q     <= 3'h0;
      store_q      <= 1'b0;
      asm_q        <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      funct3_q     <= funct3_d;
      store_q      <= store_d;
      asm_q        <= asm_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_if.resp_valid = resp_valid_q;
  assign req_if.resp_err   = resp_err_q;
  assign req_if.resp_rdata = resp_rdata_q;

endmodule
